// File: rtl/flash_prefetch.sv
// flash_prefetch: single-line read cache in front of a flash reader.
// A hit answers in one cycle. A miss fetches the aligned 32-bit line through
// the reader's enable/ready handshake. A timeout bounds the wait on the reader.
module flash_prefetch #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd20000000,
  parameter int          LINE_BYTES     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [23:0]             cpu_addr,
  input  logic                    cpu_req,
  input  logic                    cpu_invalidate,
  output logic [8*LINE_BYTES-1:0] cpu_rdata,
  output logic [7:0]              cpu_rbyte,
  output logic                    cpu_valid,
  output logic                    cpu_err,
  output logic                    cpu_busy,
  output logic [23:0]             flash_addr,
  output logic                    flash_enable,
  input  logic [8*LINE_BYTES-1:0] flash_data,
  input  logic                    flash_ready
);

  localparam int LINE_W = 8 * LINE_BYTES;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_FILL  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                valid_q, valid_d;
  logic [21:0]         tag_q, tag_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [1:0]          off_q, off_d;
  logic                inval_q, inval_d;
  logic [31:0]         tmo_q, tmo_d;
  logic [LINE_W-1:0]   rdata_q, rdata_d;
  logic [7:0]          rbyte_q, rbyte_d;
  logic                cvalid_q, cvalid_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic [23:0]         faddr_q, faddr_d;
  logic                fen_q, fen_d;

  logic                hit_s;
  logic                timeout_s;

  // An invalidate in the request cycle forces a miss; offset bits never take part.
  assign hit_s     = valid_q && !cpu_invalidate && (tag_q == cpu_addr[23:2]);
  assign timeout_s = (tmo_q == (TIMEOUT_CYCLES - 32'd1));

  // State and datapath registers, cleared asynchronously on rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      valid_q  <= 1'b0;
      tag_q    <= 22'd0;
      line_q   <= '0;
      off_q    <= 2'd0;
      inval_q  <= 1'b0;
      tmo_q    <= 32'd0;
      rdata_q  <= '0;
      rbyte_q  <= 8'd0;
      cvalid_q <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      faddr_q  <= 24'd0;
      fen_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      line_q   <= line_d;
      off_q    <= off_d;
      inval_q  <= inval_d;
      tmo_q    <= tmo_d;
      rdata_q  <= rdata_d;
      rbyte_q  <= rbyte_d;
      cvalid_q <= cvalid_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      faddr_q  <= faddr_d;
      fen_q    <= fen_d;
    end
  end

  // Next-state selection; a timeout takes priority over any reader handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_req) state_d = hit_s ? S_RESP : S_ISSUE;
        else         state_d = S_IDLE;
      end
      S_ISSUE: begin
        if (timeout_s)        state_d = S_IDLE;
        else if (flash_ready) state_d = S_WAIT;
        else                  state_d = S_ISSUE;
      end
      S_WAIT: begin
        if (timeout_s)         state_d = S_IDLE;
        else if (!flash_ready) state_d = S_FILL;
        else                   state_d = S_WAIT;
      end
      S_FILL:  state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and line-update values, computed from the current and next state.
  always_comb begin
    valid_d  = valid_q && !cpu_invalidate;
    tag_d    = tag_q;
    line_d   = line_q;
    off_d    = off_q;
    inval_d  = inval_q || cpu_invalidate;
    tmo_d    = tmo_q;
    faddr_d  = faddr_q;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          off_d = cpu_addr[1:0];
          if (!hit_s) begin
            // The line is about to be replaced, so it stops being valid now.
            faddr_d = {cpu_addr[23:2], 2'b00};
            valid_d = 1'b0;
            inval_d = 1'b0;
            tmo_d   = 32'd0;
          end else begin
            inval_d = 1'b0;
          end
        end else begin
          inval_d = 1'b0;
        end
      end
      S_ISSUE, S_WAIT: begin
        tmo_d = tmo_q + 32'd1;
        if (timeout_s) err_d = 1'b1;
        else           err_d = 1'b0;
      end
      S_FILL: begin
        line_d  = flash_data;
        tag_d   = faddr_q[23:2];
        valid_d = !(inval_q || cpu_invalidate);
      end
      default: begin
        tmo_d = tmo_q;
      end
    endcase

    fen_d    = (state_d == S_ISSUE);
    busy_d   = (state_d == S_ISSUE) || (state_d == S_WAIT) || (state_d == S_FILL);
    cvalid_d = (state_d == S_RESP);
    if (state_d == S_RESP) begin
      rdata_d = line_d;
      rbyte_d = line_d[{off_d, 3'b000} +: 8];
    end else begin
      rdata_d = rdata_q;
      rbyte_d = rbyte_q;
    end
  end

  assign cpu_rdata    = rdata_q;
  assign cpu_rbyte    = rbyte_q;
  assign cpu_valid    = cvalid_q;
  assign cpu_err      = err_q;
  assign cpu_busy     = busy_q;
  assign flash_addr   = faddr_q;
  assign flash_enable = fen_q;

endmodule

// File: tb/tb_flash_prefetch.sv
// Directed bench for flash_prefetch; the reader handshake is driven by hand.
`timescale 1ns/1ps
module tb_flash_prefetch;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [23:0] cpu_addr = 24'd0;
  logic        cpu_req = 1'b0;
  logic        cpu_invalidate = 1'b0;
  logic [31:0] cpu_rdata;
  logic [7:0]  cpu_rbyte;
  logic        cpu_valid, cpu_err, cpu_busy;
  logic [23:0] flash_addr;
  logic        flash_enable;
  logic [31:0] flash_data = 32'd0;
  logic        flash_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  flash_prefetch #(.TIMEOUT_CYCLES(32'd16), .LINE_BYTES(4)) dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_req(cpu_req),
    .cpu_invalidate(cpu_invalidate), .cpu_rdata(cpu_rdata), .cpu_rbyte(cpu_rbyte),
    .cpu_valid(cpu_valid), .cpu_err(cpu_err), .cpu_busy(cpu_busy),
    .flash_addr(flash_addr), .flash_enable(flash_enable),
    .flash_data(flash_data), .flash_ready(flash_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++; if (cpu_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", cpu_valid); end
    n_checks++; if (cpu_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", cpu_busy); end
    n_checks++; if (flash_enable !== 1'b0) begin n_fail++; $display("FAIL rst_enable: got %b want 0", flash_enable); end
    n_checks++; if (flash_addr !== 24'd0) begin n_fail++; $display("FAIL rst_faddr: got %h want 000000", flash_addr); end
    n_checks++; if (cpu_rdata !== 32'd0 || cpu_rbyte !== 8'd0 || cpu_err !== 1'b0) begin n_fail++; $display("FAIL rst_data: got %h/%h/%b want 0", cpu_rdata, cpu_rbyte, cpu_err); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_cold_miss();
    cpu_addr = 24'h000105; cpu_req = 1'b1;
    tick();
    n_checks++; if (flash_enable !== 1'b1) begin n_fail++; $display("FAIL miss_enable: got %b want 1", flash_enable); end
    n_checks++; if (flash_addr !== 24'h000104) begin n_fail++; $display("FAIL miss_faddr: got %h want 000104", flash_addr); end
    n_checks++; if (cpu_busy !== 1'b1) begin n_fail++; $display("FAIL miss_busy: got %b want 1", cpu_busy); end
    // Requests while busy must be ignored.
    cpu_addr = 24'h000300;
    tick();
    tick();
    n_checks++; if (flash_enable !== 1'b1 || flash_addr !== 24'h000104) begin n_fail++; $display("FAIL miss_hold: got en=%b addr=%h want en=1 addr=000104", flash_enable, flash_addr); end
    cpu_req = 1'b0; flash_ready = 1'b1;
    tick();
    n_checks++; if (flash_enable !== 1'b0 || cpu_busy !== 1'b1) begin n_fail++; $display("FAIL miss_wait: got en=%b busy=%b want en=0 busy=1", flash_enable, cpu_busy); end
    flash_ready = 1'b0; flash_data = 32'hDDCCBBAA;
    tick();
    n_checks++; if (cpu_valid !== 1'b0) begin n_fail++; $display("FAIL miss_early: got %b want 0", cpu_valid); end
    tick();
    n_checks++; if (cpu_valid !== 1'b1) begin n_fail++; $display("FAIL miss_valid: got %b want 1", cpu_valid); end
    n_checks++; if (cpu_rdata !== 32'hDDCCBBAA) begin n_fail++; $display("FAIL miss_rdata: got %h want DDCCBBAA", cpu_rdata); end
    n_checks++; if (cpu_rbyte !== 8'hBB) begin n_fail++; $display("FAIL miss_rbyte: got %h want BB", cpu_rbyte); end
    n_checks++; if (cpu_busy !== 1'b0) begin n_fail++; $display("FAIL miss_busy_clr: got %b want 0", cpu_busy); end
    flash_data = 32'h0;
    tick();
    n_checks++; if (cpu_valid !== 1'b0 || cpu_rdata !== 32'hDDCCBBAA) begin n_fail++; $display("FAIL miss_pulse: got v=%b d=%h want v=0 d=DDCCBBAA", cpu_valid, cpu_rdata); end
  endtask

  task automatic test_hit();
    cpu_addr = 24'h000107; cpu_req = 1'b1;
    tick();
    n_checks++; if (cpu_valid !== 1'b1 || cpu_rbyte !== 8'hDD) begin n_fail++; $display("FAIL hit_107: got v=%b b=%h want v=1 b=DD", cpu_valid, cpu_rbyte); end
    n_checks++; if (flash_enable !== 1'b0 || cpu_busy !== 1'b0) begin n_fail++; $display("FAIL hit_noflash: got en=%b busy=%b want 0 0", flash_enable, cpu_busy); end
    cpu_req = 1'b0;
    tick();
    n_checks++; if (cpu_valid !== 1'b0) begin n_fail++; $display("FAIL hit_pulse: got %b want 0", cpu_valid); end
    cpu_addr = 24'h000104; cpu_req = 1'b1;
    tick();
    n_checks++; if (cpu_valid !== 1'b1 || cpu_rbyte !== 8'hAA || cpu_rdata !== 32'hDDCCBBAA) begin n_fail++; $display("FAIL hit_104: got v=%b b=%h d=%h want 1 AA DDCCBBAA", cpu_valid, cpu_rbyte, cpu_rdata); end
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_invalidate_wait();
    cpu_addr = 24'h000200; cpu_req = 1'b1;
    tick();
    n_checks++; if (flash_enable !== 1'b1 || flash_addr !== 24'h000200) begin n_fail++; $display("FAIL inv_miss: got en=%b addr=%h want 1 000200", flash_enable, flash_addr); end
    cpu_req = 1'b0; flash_ready = 1'b1;
    tick();
    cpu_invalidate = 1'b1;
    tick();
    cpu_invalidate = 1'b0; flash_ready = 1'b0; flash_data = 32'h44332211;
    tick();
    tick();
    n_checks++; if (cpu_valid !== 1'b1 || cpu_rdata !== 32'h44332211 || cpu_rbyte !== 8'h11) begin n_fail++; $display("FAIL inv_data: got v=%b d=%h b=%h want 1 44332211 11", cpu_valid, cpu_rdata, cpu_rbyte); end
    tick();
    cpu_req = 1'b1;
    tick();
    n_checks++; if (flash_enable !== 1'b1 || cpu_valid !== 1'b0) begin n_fail++; $display("FAIL inv_refetch: got en=%b v=%b want 1 0", flash_enable, cpu_valid); end
    cpu_req = 1'b0; flash_ready = 1'b1;
    tick();
    flash_ready = 1'b0; flash_data = 32'h88776655;
    tick();
    tick();
    n_checks++; if (cpu_valid !== 1'b1 || cpu_rdata !== 32'h88776655) begin n_fail++; $display("FAIL inv_refill: got v=%b d=%h want 1 88776655", cpu_valid, cpu_rdata); end
    tick();
    cpu_addr = 24'h000202; cpu_req = 1'b1;
    tick();
    n_checks++; if (cpu_valid !== 1'b1 || cpu_rbyte !== 8'h77 || flash_enable !== 1'b0) begin n_fail++; $display("FAIL inv_hit: got v=%b b=%h en=%b want 1 77 0", cpu_valid, cpu_rbyte, flash_enable); end
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_invalidate_idle();
    cpu_addr = 24'h000200; cpu_req = 1'b1; cpu_invalidate = 1'b1;
    tick();
    n_checks++; if (flash_enable !== 1'b1 || cpu_busy !== 1'b1 || cpu_valid !== 1'b0) begin n_fail++; $display("FAIL idleinv_miss: got en=%b busy=%b v=%b want 1 1 0", flash_enable, cpu_busy, cpu_valid); end
    cpu_req = 1'b0; cpu_invalidate = 1'b0; flash_ready = 1'b1;
    tick();
    flash_ready = 1'b0; flash_data = 32'hCAFEF00D;
    tick();
    tick();
    n_checks++; if (cpu_valid !== 1'b1 || cpu_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL idleinv_fill: got v=%b d=%h want 1 CAFEF00D", cpu_valid, cpu_rdata); end
    tick();
    cpu_addr = 24'h000201; cpu_req = 1'b1;
    tick();
    n_checks++; if (cpu_valid !== 1'b1 || cpu_rbyte !== 8'hF0 || flash_enable !== 1'b0) begin n_fail++; $display("FAIL idleinv_hit: got v=%b b=%h en=%b want 1 F0 0", cpu_valid, cpu_rbyte, flash_enable); end
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int seen_valid;
    seen_valid = 0;
    cpu_addr = 24'h000400; cpu_req = 1'b1;
    tick();
    cpu_req = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (cpu_valid === 1'b1) seen_valid++;
      if (i < 16) begin
        n_checks++; if (cpu_err !== 1'b0 || flash_enable !== 1'b1) begin n_fail++; $display("FAIL tmo_early c%0d: got err=%b en=%b want 0 1", i, cpu_err, flash_enable); end
      end else begin
        n_checks++; if (cpu_err !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got %b want 1", cpu_err); end
        n_checks++; if (flash_enable !== 1'b0 || cpu_busy !== 1'b0) begin n_fail++; $display("FAIL tmo_idle: got en=%b busy=%b want 0 0", flash_enable, cpu_busy); end
      end
    end
    tick();
    n_checks++; if (cpu_err !== 1'b0 || seen_valid != 0 || cpu_valid !== 1'b0) begin n_fail++; $display("FAIL tmo_pulse: got err=%b valids=%0d want 0 0", cpu_err, seen_valid); end
    // The line for 0x200 was replaced by the aborted fetch and must now miss.
    cpu_addr = 24'h000201; cpu_req = 1'b1;
    tick();
    n_checks++; if (flash_enable !== 1'b1 || cpu_valid !== 1'b0) begin n_fail++; $display("FAIL tmo_invalid: got en=%b v=%b want 1 0", flash_enable, cpu_valid); end
    cpu_req = 1'b0;
  endtask

  task automatic test_reset_wait();
    int seen_valid;
    seen_valid = 0;
    flash_ready = 1'b1;
    tick();
    rst = 1'b1;
    #2;
    n_checks++; if (cpu_busy !== 1'b0 || flash_enable !== 1'b0 || flash_addr !== 24'd0) begin n_fail++; $display("FAIL rstw_async: got busy=%b en=%b addr=%h want 0 0 0", cpu_busy, flash_enable, flash_addr); end
    tick();
    rst = 1'b0; flash_ready = 1'b0; flash_data = 32'h12345678;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (cpu_valid === 1'b1) seen_valid++;
    end
    n_checks++; if (seen_valid != 0 || cpu_rdata !== 32'd0 || cpu_busy !== 1'b0) begin n_fail++; $display("FAIL rstw_ignore: got valids=%0d d=%h busy=%b want 0 0 0", seen_valid, cpu_rdata, cpu_busy); end
    cpu_req = 1'b1;
    tick();
    n_checks++; if (flash_enable !== 1'b1 || flash_addr !== 24'h000200) begin n_fail++; $display("FAIL rstw_miss: got en=%b addr=%h want 1 000200", flash_enable, flash_addr); end
    cpu_req = 1'b0; flash_ready = 1'b1;
    tick();
    flash_ready = 1'b0;
    tick();
    tick();
    n_checks++; if (cpu_valid !== 1'b1 || cpu_rbyte !== 8'h56) begin n_fail++; $display("FAIL rstw_fill: got v=%b b=%h want 1 56", cpu_valid, cpu_rbyte); end
    tick();
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_invalidate_wait();
    test_invalidate_idle();
    test_timeout();
    test_reset_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
